// File: rtl/fb_load_ctrl_pkg.sv
// Shared frame-buffer definitions for the picture loader and the scan-out reader.
// Geometry, base address, RGB444 pixel type and the loader state encoding.
package fb_load_ctrl_pkg;

  localparam int IMG_W    = 400;
  localparam int IMG_H    = 300;
  localparam int FB_DEPTH = IMG_W * IMG_H;
  // Address 0 is reserved as the scan-out blanking word, so pixels start at 1.
  localparam int FB_BASE  = 1;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  function automatic int fb_addr_of(input int pix_idx);
    return pix_idx + FB_BASE;
  endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Pixel counter for the frame-buffer loader: load-to-zero, count enable,
// terminal flag once TERM pixels have been written.
module fb_addr_counter
  import fb_load_ctrl_pkg::*;
#(
  parameter int W    = 17,
  parameter int TERM = FB_DEPTH
) (
  input  logic         CLK,
  input  logic         Rst_n,
  input  logic         load_zero,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         term
);

  localparam logic [W-1:0] TERM_W = W'(TERM);

  // A load coinciding with an enable means the first write is issued on entry.
  always_ff @(posedge CLK) begin
    if (!Rst_n)         cnt <= '0;
    else if (load_zero) cnt <= en ? W'(1) : '0;
    else if (en)        cnt <= cnt + W'(1);
  end

  assign term = (cnt == TERM_W);

endmodule

// File: rtl/fb_load_ctrl.sv
// Write-side controller for the VGA frame buffer: streams decoder pixels or a
// constant fill into the shared BRAM port, yielding whenever the display claims it.
//
// state | meaning
// IDLE  | waiting for start/clear, pix_cnt holds last count
// CLEAR | writing latched fill colour, one word per free slot
// LOAD  | accepting stream pixels, one write per handshake
// DONE  | one-cycle completion pulse
module fb_load_ctrl #(
  parameter int IMG_W  = 400,
  parameter int IMG_H  = 300,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              CLK,
  input  logic              Rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              abort,
  input  logic [PIX_W-1:0]  fill_color,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  output logic              s_ready,
  input  logic              disp_req,
  output logic              wea,
  output logic [ADDR_W-1:0] addr,
  output logic [PIX_W-1:0]  dina,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_cnt
);

  import fb_load_ctrl_pkg::*;

  localparam int                DEPTH  = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(FB_BASE);

  fb_state_e         state, state_nxt;
  logic [PIX_W-1:0]  fill_q;
  logic [PIX_W-1:0]  wr_data;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_issue;
  logic              cnt_load;
  logic              cnt_term;

  fb_addr_counter #(
    .W    (ADDR_W),
    .TERM (DEPTH)
  ) u_cnt (
    .CLK       (CLK),
    .Rst_n     (Rst_n),
    .load_zero (cnt_load),
    .en        (wr_issue),
    .cnt       (pix_cnt),
    .term      (cnt_term)
  );

  // Abort gates the handshake immediately so no pixel is taken that will never be written.
  assign s_ready = (state == LOAD) && !disp_req && !abort && !cnt_term;
  assign busy    = (state == CLEAR) || (state == LOAD);
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    wr_issue  = 1'b0;
    cnt_load  = 1'b0;
    wr_data   = s_data;

    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          cnt_load  = 1'b1;
          wr_issue  = !disp_req;
          wr_data   = fill_color;
        end else if (start) begin
          state_nxt = LOAD;
          cnt_load  = 1'b1;
        end
      end
      CLEAR: begin
        wr_data = fill_q;
        if (cnt_term) state_nxt = DONE;
        else          wr_issue  = !disp_req;
      end
      LOAD: begin
        if (cnt_term) state_nxt = DONE;
        else          wr_issue  = s_valid && s_ready;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      state_nxt = IDLE;
      wr_issue  = 1'b0;
      cnt_load  = 1'b0;
    end

    wr_addr = (cnt_load ? '0 : pix_cnt) + BASE_A;
  end

  always_ff @(posedge CLK) begin
    if (!Rst_n) begin
      state  <= IDLE;
      wea    <= 1'b0;
      addr   <= '0;
      dina   <= '0;
      fill_q <= '0;
    end else begin
      state <= state_nxt;
      wea   <= wr_issue;
      if (wr_issue) begin
        addr <= wr_addr;
        dina <= wr_data;
      end
      if ((state == IDLE) && clear && !abort) fill_q <= fill_color;
    end
  end

endmodule

// File: tb/tb_fb_load_ctrl.sv
// Scoreboard bench for fb_load_ctrl on a reduced 40x30 frame: expected writes are
// queued at stimulus time and matched by a monitor that watches the BRAM port.
module tb_fb_load_ctrl;

  localparam int IW = 40;
  localparam int IH = 30;
  localparam int N  = IW * IH;
  localparam int AW = 17;
  localparam int PW = 12;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [PW-1:0] d;
  } wr_t;

  logic          CLK = 1'b0;
  logic          Rst_n;
  logic          start, clear, abort, s_valid, disp_req;
  logic [PW-1:0] fill_color, s_data;
  logic          s_ready, wea, busy, done;
  logic [AW-1:0] addr, pix_cnt;
  logic [PW-1:0] dina;

  int  checks    = 0;
  int  failures  = 0;
  int  cyc       = 0;
  int  done_cnt  = 0;
  int  done_cyc  = 0;
  int  clear_cyc = 0;
  int  model_cnt = 0;
  logic prev_disp = 1'b0;
  wr_t exp_q[$];
  logic [PW-1:0] mem_w [0:N];

  fb_load_ctrl #(
    .IMG_W (IW),
    .IMG_H (IH),
    .ADDR_W(AW),
    .PIX_W (PW)
  ) dut (
    .CLK        (CLK),
    .Rst_n      (Rst_n),
    .start      (start),
    .clear      (clear),
    .abort      (abort),
    .fill_color (fill_color),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .disp_req   (disp_req),
    .wea        (wea),
    .addr       (addr),
    .dina       (dina),
    .busy       (busy),
    .done       (done),
    .pix_cnt    (pix_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    wr_t e;
    if (prev_disp) chk("no_write_after_disp_req", longint'(wea), 0);
    if (wea === 1'b1) begin
      chk("write_addr_nonzero", longint'(addr != 0), 1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing pending", addr, dina);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", longint'(addr), longint'(e.a));
        chk("write_data", longint'(dina), longint'(e.d));
      end
      if (int'(addr) <= N) mem_w[addr] = dina;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_low_at_done", longint'(busy), 0);
      chk("pix_cnt_at_done", longint'(pix_cnt), N);
    end
    prev_disp = disp_req;
  end

  task automatic half();
    wr_t e;
    @(negedge CLK);
    if (s_valid && s_ready) begin
      e.a = AW'(model_cnt + 1);
      e.d = s_data;
      exp_q.push_back(e);
      model_cnt++;
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  task automatic mem_init();
    for (int a = 0; a <= N; a++) mem_w[a] = 12'hFFF;
  endtask

  task automatic chk_mem(input string name, input bit ramp, input logic [PW-1:0] col);
    int bad = 0;
    for (int a = 1; a <= N; a++)
      if (mem_w[a] !== (ramp ? PW'(a - 1) : col)) bad++;
    chk(name, bad, 0);
    chk("addr0_untouched", longint'(mem_w[0]), 12'hFFF);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wea",     longint'(wea), 0);
    chk("rst_addr",    longint'(addr), 0);
    chk("rst_dina",    longint'(dina), 0);
    chk("rst_s_ready", longint'(s_ready), 0);
    chk("rst_busy",    longint'(busy), 0);
    chk("rst_done",    longint'(done), 0);
    chk("rst_pix_cnt", longint'(pix_cnt), 0);
  endtask

  task automatic settle();
    repeat (3) begin half(); adv(); end
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_not_busy", longint'(busy), 0);
  endtask

  // dmode: 0 free port, 1 disp_req toggling, 2 random. stop_at > 0 leaves LOAD running.
  task automatic run_load(input int dmode, input bit stall, input int stop_at);
    int d0, budget;
    d0        = done_cnt;
    model_cnt = 0;
    disp_req  = 1'b0;
    start     = 1'b1;
    half(); adv();
    start  = 1'b0;
    budget = 0;
    while (done_cnt == d0 && budget < 10 * N) begin
      if (stop_at > 0 && model_cnt == stop_at) break;
      s_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = PW'(model_cnt);
      case (dmode)
        0:       disp_req = 1'b0;
        1:       disp_req = ~disp_req;
        default: disp_req = ($urandom_range(0, 3) == 0);
      endcase
      half(); adv();
      budget++;
    end
    s_valid  = 1'b0;
    disp_req = 1'b0;
    if (stop_at == 0) chk("load_done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_clear(input logic [PW-1:0] col, input bit with_start, input bit rnd_disp);
    int d0, budget, sr_bad;
    wr_t e;
    d0     = done_cnt;
    sr_bad = 0;
    for (int i = 1; i <= N; i++) begin
      e.a = AW'(i);
      e.d = col;
      exp_q.push_back(e);
    end
    clear      = 1'b1;
    start      = with_start;
    fill_color = col;
    disp_req   = 1'b0;
    clear_cyc  = cyc;
    half(); adv();
    clear      = 1'b0;
    start      = 1'b0;
    fill_color = ~col;
    budget     = 0;
    while (done_cnt == d0 && budget < 8 * N) begin
      disp_req = rnd_disp ? ($urandom_range(0, 2) == 0) : 1'b0;
      start    = (budget == 100);
      s_valid  = 1'b1;
      s_data   = PW'($urandom);
      half();
      if (s_ready) sr_bad++;
      adv();
      budget++;
    end
    start    = 1'b0;
    s_valid  = 1'b0;
    disp_req = 1'b0;
    chk("clear_done_seen", done_cnt - d0, 1);
    chk("clear_s_ready_low", sr_bad, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [PW-1:0] col;
    Rst_n = 1'b0; start = 1'b0; clear = 1'b0; abort = 1'b0;
    s_valid = 1'b0; disp_req = 1'b0; fill_color = '0; s_data = '0;
    mem_init();
    adv(); adv();
    Rst_n = 1'b1;
    half();
    chk_reset_vals();
    adv();

    // Full clear with a free port: exact latency, every word red.
    mem_init();
    run_clear(12'hF00, 1'b0, 1'b0);
    chk("clear_done_latency", done_cyc - clear_cyc, N + 1);
    settle();
    chk_mem("clear_mem", 1'b0, 12'hF00);

    // Stream load with the display claiming every other cycle.
    mem_init();
    run_load(1, 1'b0, 0);
    settle();
    chk_mem("load_toggle_mem", 1'b1, '0);

    // Stream load with random stalls on both sides.
    mem_init();
    run_load(2, 1'b1, 0);
    settle();
    chk_mem("load_stall_mem", 1'b1, '0);

    // Abort after 1000 accepted pixels.
    d0 = done_cnt;
    run_load(0, 1'b0, 1000);
    abort   = 1'b1;
    s_valid = 1'b1;
    half();
    chk("abort_s_ready", longint'(s_ready), 0);
    adv();
    abort = 1'b0;
    half();
    chk("abort_busy", longint'(busy), 0);
    chk("abort_pix_cnt", longint'(pix_cnt), 1000);
    adv();
    repeat (20) begin half(); adv(); end
    s_valid = 1'b0;
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_queue", exp_q.size(), 0);

    // start and clear together: clear wins, start mid-clear ignored.
    mem_init();
    col = PW'($urandom);
    run_clear(col, 1'b1, 1'b1);
    settle();
    chk_mem("clear_start_mem", 1'b0, col);

    // Reset in the middle of a load, then a fresh load from address 1.
    run_load(0, 1'b0, 50);
    Rst_n = 1'b0;
    half(); adv();
    Rst_n = 1'b1;
    half();
    chk_reset_vals();
    chk("reset_queue", exp_q.size(), 0);
    adv();
    mem_init();
    run_load(2, 1'b1, 0);
    settle();
    chk_mem("reload_mem", 1'b1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
